mantissa_seq_multiplier: RTL and testbench

Iterative unsigned shift-and-add multiplier that time-shares one `RippleCarryAdder` instance across N cycles to form the 2N-bit product of two N-bit mantissas. It replaces a fully parallel array in the floating-point multiplier datapath, trading latency for area. Sign, exponent and normalisation logic sit upstream and downstream of this block. Operands enter and the product leaves through valid/ready handshakes.

---
 rtl/mantissa_seq_multiplier.sv | 141 ++++++++++++++
 tb/tb_mantissa_seq_multiplier.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_seq_multiplier.sv
// mantissa_seq_multiplier
//   Iterative unsigned shift-and-add multiplier. One N-bit ripple-carry adder
//   is reused over N cycles to build the 2N-bit product of two N-bit
//   mantissas. Operands are accepted on a start_valid/start_ready handshake.
//   The product is offered on a result_valid/result_ready handshake.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   start_valid   a/b are valid
//   start_ready   block can accept operands (IDLE only)
//   a, b          N-bit unsigned multiplicand / multiplier
//   result_valid  product is valid (DONE)
//   result_ready  consumer accepts product
//   product       2N-bit unsigned a*b, held until handshake
//   busy          high in RUN or DONE
//
// RippleCarryAdder
//   Plain N-bit ripple-carry adder. The overflow output gives the signed
//   overflow flag. This block uses the adder for unsigned arithmetic only.

module RippleCarryAdder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
);
  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[N];
  assign overflow = c[N] ^ c[N-1];
endmodule

// state | meaning
// IDLE  | waiting for operands, start_ready high
// RUN   | one add/shift step per cycle, N steps
// DONE  | product presented, waiting for result_ready
module mantissa_seq_multiplier #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           result_valid,
  input  logic           result_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);
  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  mcand, hi, lo;
  logic [CW-1:0] cnt;

  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic           cout;
  logic [2*N-1:0] acc_next;

  assign addend = lo[0] ? mcand : '0;

  RippleCarryAdder #(.N(N)) u_rca (
    .a        (hi),
    .b        (addend),
    .cin      (1'b0),
    .sum      (sum),
    .cout     (cout),
    .overflow ()
  );

  // The carry lands in the top bit of hi. The full product fits in 2N bits,
  // so the shifted-out bit 0 is the only bit dropped.
  assign acc_next = {cout, sum, lo[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid)  state_d = RUN;
      RUN:     if (cnt == LAST)  state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // start_ready stays low while rst is high, even though the state may
  // already read IDLE.
  assign start_ready  = (state_q == IDLE) && !rst;
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
          end
        end
        RUN: begin
          {hi, lo} <= acc_next;
          cnt      <= cnt + 1'b1;
          // product is loaded only on the final step, so it holds its old
          // value through IDLE and RUN.
          if (cnt == LAST) product <= acc_next;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mantissa_seq_multiplier.sv
module tb_mantissa_seq_multiplier;
  localparam int N8  = 8;
  localparam int N24 = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst8, sv8, sr8, rv8, rr8, busy8;
  logic [7:0]   a8, b8;
  logic [15:0]  p8;
  logic         rst24, sv24, sr24, rv24, rr24, busy24;
  logic [23:0]  a24, b24;
  logic [47:0]  p24;

  mantissa_seq_multiplier #(.N(N8)) u_dut8 (
    .clk(clk), .rst(rst8), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .result_valid(rv8), .result_ready(rr8),
    .product(p8), .busy(busy8)
  );

  mantissa_seq_multiplier #(.N(N24)) u_dut24 (
    .clk(clk), .rst(rst24), .start_valid(sv24), .start_ready(sr24),
    .a(a24), .b(b24), .result_valid(rv24), .result_ready(rr24),
    .product(p24), .busy(busy24)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc8_n = 0, hs8_n = 0, acc24_n = 0, hs24_n = 0;
  logic stall_en = 1'b0;

  logic [15:0] exp8_q[$];
  logic [47:0] exp24_q[$];
  int          acc8_q[$];
  int          acc24_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    int t = 0;
    @(negedge clk);
    while (!sr8 && t < 300) begin @(negedge clk); t++; end
    if (!sr8) begin chk("send8_ready_timeout", {63'd0, sr8}, 64'd1); return; end
    a8 = a; b8 = b; sv8 = 1'b1;
    exp8_q.push_back(e);
    @(posedge clk); #1;
    acc8_q.push_back(cyc); acc8_n++;
    sv8 = 1'b0; a8 = ~a; b8 = ~b;
  endtask

  task automatic send24(input logic [23:0] a, input logic [23:0] b, input logic [47:0] e);
    int t = 0;
    @(negedge clk);
    while (!sr24 && t < 500) begin @(negedge clk); t++; end
    if (!sr24) begin chk("send24_ready_timeout", {63'd0, sr24}, 64'd1); return; end
    a24 = a; b24 = b; sv24 = 1'b1;
    exp24_q.push_back(e);
    @(posedge clk); #1;
    acc24_q.push_back(cyc); acc24_n++;
    sv24 = 1'b0; a24 = ~a; b24 = ~b;
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while ((exp8_q.size() != 0 || exp24_q.size() != 0) && t < limit) begin
      @(negedge clk); t++;
    end
    chk("drain8_pending", 64'(exp8_q.size()), 64'd0);
    chk("drain24_pending", 64'(exp24_q.size()), 64'd0);
  endtask

  // Scoreboard monitors: compare every presented product against the queue
  // head, and pop on a completed handshake.
  logic pv8 = 1'b0;
  always @(negedge clk) begin
    if (rst8) pv8 = 1'b0;
    else begin
      if (rv8 && !pv8) begin
        if (acc8_q.size() > 0) chk("lat8", 64'(cyc - acc8_q.pop_front()), 64'(N8));
        else chk("lat8_unexpected", {63'd0, rv8}, 64'd0);
      end
      if (rv8) begin
        if (exp8_q.size() == 0) chk("spurious8", {63'd0, rv8}, 64'd0);
        else begin
          chk("prod8", 64'(p8), 64'(exp8_q[0]));
          chk("sr8_in_done", {63'd0, sr8}, 64'd0);
          chk("busy8_in_done", {63'd0, busy8}, 64'd1);
          if (rr8) begin void'(exp8_q.pop_front()); hs8_n++; end
        end
      end
      pv8 = rv8;
    end
  end

  logic pv24 = 1'b0;
  always @(negedge clk) begin
    if (rst24) pv24 = 1'b0;
    else begin
      if (rv24 && !pv24) begin
        if (acc24_q.size() > 0) chk("lat24", 64'(cyc - acc24_q.pop_front()), 64'(N24));
        else chk("lat24_unexpected", {63'd0, rv24}, 64'd0);
      end
      if (rv24) begin
        if (exp24_q.size() == 0) chk("spurious24", {63'd0, rv24}, 64'd0);
        else begin
          chk("prod24", 64'(p24), 64'(exp24_q[0]));
          chk("sr24_in_done", {63'd0, sr24}, 64'd0);
          if (rr24) begin void'(exp24_q.pop_front()); hs24_n++; end
        end
      end
      pv24 = rv24;
    end
  end

  initial begin
    rr24 = 1'b1;
    forever begin
      @(posedge clk); #1;
      rr24 = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    logic [23:0] ra, rb;
    int t;
    rst8 = 1'b1; rst24 = 1'b1;
    sv8 = 1'b0; sv24 = 1'b0; rr8 = 1'b1;
    a8 = '0; b8 = '0; a24 = '0; b24 = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_sr8_low", {63'd0, sr8}, 64'd0);
    chk("reset_sr24_low", {63'd0, sr24}, 64'd0);
    chk("reset_busy8", {63'd0, busy8}, 64'd0);
    chk("reset_rv8", {63'd0, rv8}, 64'd0);
    chk("reset_p8", 64'(p8), 64'd0);
    chk("reset_p24", 64'(p24), 64'd0);
    rst8 = 1'b0; rst24 = 1'b0;
    @(negedge clk);
    chk("post_reset_sr8", {63'd0, sr8}, 64'd1);
    chk("post_reset_sr24", {63'd0, sr24}, 64'd1);

    send8(8'hB5, 8'h3C, 16'h2A6C);
    send8(8'hFF, 8'hFF, 16'hFE01);
    send8(8'h00, 8'hA7, 16'h0000);
    send8(8'h01, 8'hA7, 16'h00A7);
    send24(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    send24(24'h800000, 24'h800000, 48'h400000000000);
    drain(200);

    // Backpressure, with operand pulses in RUN and DONE that must be ignored.
    @(posedge clk); #1;
    rr8 = 1'b0;
    send8(8'h5A, 8'hC3, 16'h448E);
    repeat (3) @(posedge clk);
    #1; sv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1; sv8 = 1'b0;
    t = 0;
    while (!rv8 && t < 50) begin @(negedge clk); t++; end
    chk("bp_rv8_seen", {63'd0, rv8}, 64'd1);
    @(posedge clk); #1; sv8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(posedge clk); #1; sv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1; rr8 = 1'b1;
    drain(50);
    repeat (N8 + 4) @(posedge clk);

    // Reset during RUN iteration 4 discards the operation.
    send8(8'h77, 8'h99, 16'h471F);
    repeat (3) @(posedge clk);
    #1; rst8 = 1'b1;
    @(posedge clk); #1;
    chk("midrun_sr8_in_rst", {63'd0, sr8}, 64'd0);
    chk("midrun_busy8", {63'd0, busy8}, 64'd0);
    chk("midrun_rv8", {63'd0, rv8}, 64'd0);
    chk("midrun_p8", 64'(p8), 64'd0);
    exp8_q.delete(); acc8_q.delete(); acc8_n--;
    rst8 = 1'b0;
    @(negedge clk);
    chk("midrun_sr8_after", {63'd0, sr8}, 64'd1);
    send8(8'h12, 8'h34, 16'h03A8);
    drain(50);

    stall_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 24'($urandom());
      rb = 24'($urandom());
      if (i % 97 == 0) ra = 24'hFFFFFF;
      if (i % 89 == 0) rb = 24'h000000;
      send24(ra, rb, 48'(ra) * 48'(rb));
    end
    drain(2000);
    stall_en = 1'b0;

    chk("hs8_vs_acc8", 64'(hs8_n), 64'(acc8_n));
    chk("hs24_vs_acc24", 64'(hs24_n), 64'(acc24_n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
